// File: rtl/sample_rate_gen_pkg.sv
// Shared types and width helpers for the sample-rate generator.
package sample_rate_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } div_state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input longint unsigned value);
    int unsigned width;
    width = 0;
    while ((64'd1 << width) < value) begin
      width++;
    end
    return width;
  endfunction

  // Dividend width, which is also the number of divide iterations.
  function automatic int unsigned div_width(input longint unsigned clk_hz,
                                            input int unsigned step_w);
    return clog2(clk_hz + 64'd1) + step_w;
  endfunction

  function automatic int unsigned ch_width(input int unsigned channels);
    return (channels > 1) ? clog2(64'(channels)) : 1;
  endfunction

endpackage

// File: rtl/sample_rate_gen_if.sv
// Configuration request channel of the sample-rate generator.
interface sample_rate_gen_if #(
  parameter int unsigned CH_W   = 1,
  parameter int unsigned FREQ_W = 12,
  parameter int unsigned STEP_W = 8
);

  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [FREQ_W-1:0] cfg_freq;
  logic [STEP_W-1:0] cfg_step;
  logic              cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_freq, cfg_step,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_freq, cfg_step,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/sample_rate_gen_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
module seq_divider
  import sample_rate_pkg::*;
#(
  parameter int unsigned WIDTH = 35
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int unsigned CNT_BITS = clog2(64'(WIDTH) + 64'd1);

  logic [WIDTH-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0]    quo_q, quo_d;
  logic [WIDTH-1:0]    dvs_q, dvs_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic [WIDTH:0]      rem_shift;
  logic [WIDTH:0]      rem_sub;

  // Dividend bits shift out of quo while quotient bits shift in from the right.
  always_comb begin
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, dvs_q};
    if (start) begin
      rem_d  = '0;
      quo_d  = dividend;
      dvs_d  = divisor;
      cnt_d  = CNT_BITS'(WIDTH);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (!rem_sub[WIDTH]) begin
        rem_d = rem_sub[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = rem_shift[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q - CNT_BITS'(1);
      if (cnt_q == CNT_BITS'(1)) begin
        busy_d = 1'b0;
      end
    end
  end

  // Iteration state; reset abandons any divide in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // High during the final iteration; quotient is complete the following cycle.
  assign done     = busy_q && (cnt_q == CNT_BITS'(1));
  assign quotient = quo_q;

endmodule

// File: rtl/sample_rate_gen.sv
// Multi-channel sample strobe generator with a shared sequential period divider.
module sample_rate_gen
  import sample_rate_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned FREQ_W    = 12,
  parameter int unsigned STEP_W    = 8,
  parameter int unsigned TABLE_LEN = 8192,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                      CLOCK,
  input  logic                      reset,
  sample_rate_gen_if.slave          cfg,
  input  logic [CHANNELS-1:0]       enable,
  output logic [CHANNELS-1:0]       strobe,
  output logic [CHANNELS-1:0]       square,
  output logic [CHANNELS*CNT_W-1:0] period
);

  localparam int unsigned CH_W   = ch_width(CHANNELS);
  localparam int unsigned DIV_W  = div_width(64'(CLK_HZ), STEP_W);
  localparam int unsigned TBL_SH = clog2(64'(TABLE_LEN));
  localparam int unsigned EXT_W  = (DIV_W > CNT_W) ? DIV_W : CNT_W;

  div_state_t       state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             cfg_bad;
  logic             accept;
  logic             div_start;
  logic             div_done;
  logic [DIV_W-1:0] dividend;
  logic [DIV_W-1:0] divisor;
  logic [DIV_W-1:0] quotient;
  logic [EXT_W-1:0] quo_ext;
  logic [CNT_W-1:0] clamped;

  // Request validation and divider FSM next state.
  always_comb begin
    cfg_bad   = (32'(cfg.cfg_ch) >= CHANNELS) || (cfg.cfg_freq == '0) || (cfg.cfg_step == '0);
    accept    = cfg.cfg_valid && ready_q;
    dividend  = DIV_W'(CLK_HZ) * DIV_W'(cfg.cfg_step);
    divisor   = DIV_W'(cfg.cfg_freq) << TBL_SH;
    state_d   = state_q;
    ch_d      = ch_q;
    err_d     = 1'b0;
    div_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (cfg_bad) begin
            err_d = 1'b1;
          end else begin
            div_start = 1'b1;
            ch_d      = CH_W'(cfg.cfg_ch);
            state_d   = DIV;
          end
        end
      end
      DIV: begin
        if (div_done) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // FSM and handshake output registers.
  always_ff @(posedge CLOCK) begin
    if (!reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_err   = err_q;

  seq_divider #(
    .WIDTH(DIV_W)
  ) u_div (
    .clk     (CLOCK),
    .rst_n   (reset),
    .start   (div_start),
    .dividend(dividend),
    .divisor (divisor),
    .done    (div_done),
    .quotient(quotient)
  );

  // Saturate to the counter range and keep at least a two-cycle period.
  always_comb begin
    quo_ext = EXT_W'(quotient);
    if (quo_ext > EXT_W'({CNT_W{1'b1}})) begin
      clamped = '1;
    end else if (quo_ext < EXT_W'(2)) begin
      clamped = CNT_W'(2);
    end else begin
      clamped = quo_ext[CNT_W-1:0];
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] pend_val_q, pend_val_d;
    logic             pend_q, pend_d;
    logic             strobe_q, strobe_d;
    logic             square_q, square_d;
    logic             write_now;
    logic             wrap;

    // Strobe is registered, so it is predicted from the next count value.
    // A DONE write landing on a wrap stays pending: the wrap consumes pend_q only.
    always_comb begin
      cnt_d      = cnt_q;
      period_d   = period_q;
      pend_val_d = pend_val_q;
      pend_d     = pend_q;
      write_now  = (state_q == DONE) && (32'(ch_q) == 32'(k));
      wrap       = enable[k] && (cnt_q == period_q - CNT_W'(1));
      if (!enable[k] || wrap) begin
        cnt_d = '0;
        if (pend_q) begin
          period_d = pend_val_q;
          pend_d   = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (write_now) begin
        pend_val_d = clamped;
        pend_d     = 1'b1;
      end
      strobe_d = enable[k] && (cnt_d == period_d - CNT_W'(1));
      square_d = enable[k] && (square_q ^ strobe_d);
    end

    // Per-channel counter, period and pending registers.
    always_ff @(posedge CLOCK) begin
      if (!reset) begin
        cnt_q      <= '0;
        period_q   <= CNT_W'(2);
        pend_val_q <= CNT_W'(2);
        pend_q     <= 1'b0;
        strobe_q   <= 1'b0;
        square_q   <= 1'b0;
      end else begin
        cnt_q      <= cnt_d;
        period_q   <= period_d;
        pend_val_q <= pend_val_d;
        pend_q     <= pend_d;
        strobe_q   <= strobe_d;
        square_q   <= square_d;
      end
    end

    assign strobe[k]                = strobe_q;
    assign square[k]                = square_q;
    assign period[k*CNT_W +: CNT_W] = period_q;
  end

endmodule

// File: tb/tb_sample_rate_gen.sv
// Directed bench for sample_rate_gen with three channels.
module tb_sample_rate_gen;

  localparam int unsigned CHANNELS = 3;
  localparam int unsigned CNT_W    = 32;
  localparam int unsigned CH_W     = 2;

  logic                      CLOCK = 1'b0;
  logic                      reset;
  logic [CHANNELS-1:0]       enable;
  logic [CHANNELS-1:0]       strobe;
  logic [CHANNELS-1:0]       square;
  logic [CHANNELS*CNT_W-1:0] period;

  sample_rate_gen_if #(.CH_W(CH_W), .FREQ_W(12), .STEP_W(8)) cfg_if ();

  sample_rate_gen #(
    .CLK_HZ   (100_000_000),
    .CHANNELS (CHANNELS),
    .FREQ_W   (12),
    .STEP_W   (8),
    .TABLE_LEN(8192),
    .CNT_W    (CNT_W)
  ) dut (
    .CLOCK (CLOCK),
    .reset (reset),
    .cfg   (cfg_if.slave),
    .enable(enable),
    .strobe(strobe),
    .square(square),
    .period(period)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [CH_W-1:0]  ch;
    logic [11:0]      freq;
    logic [7:0]       step;
    bit               err;
    logic [CNT_W-1:0] per;
  } cfg_vec_t;

  int unsigned      n_checks = 0;
  int unsigned      n_fail   = 0;
  logic [CNT_W-1:0] exp_period [CHANNELS];
  cfg_vec_t         vecs [8];

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_lanes(input string name);
    for (int k = 0; k < int'(CHANNELS); k++) begin
      check($sformatf("%s period lane%0d", name, k), 64'(period[k*CNT_W +: CNT_W]),
            64'(exp_period[k]));
    end
  endtask

  task automatic run_cfg(input cfg_vec_t v, input string name);
    int unsigned busy;
    check({name, " ready before"}, 64'(cfg_if.cfg_ready), 64'(1));
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = v.ch;
    cfg_if.cfg_freq  = v.freq;
    cfg_if.cfg_step  = v.step;
    tick();
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = CH_W'($urandom);
    cfg_if.cfg_freq  = 12'($urandom);
    cfg_if.cfg_step  = 8'($urandom);
    check({name, " err pulse"}, 64'(cfg_if.cfg_err), 64'(v.err));
    busy = 0;
    while (cfg_if.cfg_ready !== 1'b1 && busy < 100) begin
      busy++;
      tick();
    end
    check({name, " ready-low cycles"}, 64'(busy), v.err ? 64'd0 : 64'd36);
    if (!v.err) exp_period[v.ch] = v.per;
    tick();
    tick();
    check({name, " err cleared"}, 64'(cfg_if.cfg_err), 64'(0));
    check_lanes(name);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit e0, e1, e2, s0, s1, s2;

    vecs[0] = '{ch: 2'd2, freq: 12'd1,    step: 8'd255, err: 1'b0, per: 32'd3112792};
    vecs[1] = '{ch: 2'd2, freq: 12'd4095, step: 8'd1,   err: 1'b0, per: 32'd2};
    vecs[2] = '{ch: 2'd0, freq: 12'd1000, step: 8'd1,   err: 1'b0, per: 32'd12};
    vecs[3] = '{ch: 2'd1, freq: 12'd2828, step: 8'd255, err: 1'b0, per: 32'd1100};
    vecs[4] = '{ch: 2'd1, freq: 12'd0,    step: 8'd1,   err: 1'b1, per: 32'd0};
    vecs[5] = '{ch: 2'd1, freq: 12'd500,  step: 8'd0,   err: 1'b1, per: 32'd0};
    vecs[6] = '{ch: 2'd3, freq: 12'd500,  step: 8'd1,   err: 1'b1, per: 32'd0};
    vecs[7] = '{ch: 2'd1, freq: 12'd1000, step: 8'd1,   err: 1'b0, per: 32'd12};

    // Reset with random inputs
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cfg_if.cfg_valid = 1'($urandom);
      cfg_if.cfg_ch    = CH_W'($urandom);
      cfg_if.cfg_freq  = 12'($urandom);
      cfg_if.cfg_step  = 8'($urandom);
      enable           = 3'($urandom);
      tick();
    end
    for (int k = 0; k < int'(CHANNELS); k++) exp_period[k] = 32'd2;
    check("reset ready", 64'(cfg_if.cfg_ready), 64'(1));
    check("reset err", 64'(cfg_if.cfg_err), 64'(0));
    check("reset strobe", 64'(strobe), 64'(0));
    check("reset square", 64'(square), 64'(0));
    check_lanes("reset");
    reset            = 1'b1;
    cfg_if.cfg_valid = 1'b0;
    enable           = '0;
    tick();
    tick();

    // Configuration vectors (all channels disabled, so periods apply at once)
    for (int i = 0; i < 8; i++) begin
      run_cfg(vecs[i], $sformatf("vec%0d", i));
    end

    // Baseline: ch0 period 12, ch2 period 2, enabled together
    enable = 3'b101;
    s0 = 1'b0;
    s2 = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      e0 = (i >= 11) && ((i - 11) % 12 == 0);
      e2 = (i % 2 == 1);
      s0 = s0 ^ e0;
      s2 = s2 ^ e2;
      check($sformatf("base strobe0 c%0d", i), 64'(strobe[0]), 64'(e0));
      check($sformatf("base strobe1 c%0d", i), 64'(strobe[1]), 64'(0));
      check($sformatf("base strobe2 c%0d", i), 64'(strobe[2]), 64'(e2));
      check($sformatf("base square0 c%0d", i), 64'(square[0]), 64'(s0));
      check($sformatf("base square2 c%0d", i), 64'(square[2]), 64'(s2));
    end
    enable = '0;
    tick();
    check("disable strobe", 64'(strobe), 64'(0));
    check("disable square", 64'(square), 64'(0));
    tick();

    // Live retune of ch1 from 12 to 24; DONE lands on the wrap at cycle 47
    enable = 3'b010;
    s1 = 1'b0;
    for (int i = 1; i <= 140; i++) begin
      tick();
      if (i <= 59) e1 = (i >= 11) && ((i - 11) % 12 == 0);
      else         e1 = ((i - 59) % 24 == 0);
      s1 = s1 ^ e1;
      check($sformatf("retune strobe1 c%0d", i), 64'(strobe[1]), 64'(e1));
      check($sformatf("retune square1 c%0d", i), 64'(square[1]), 64'(s1));
      check($sformatf("retune others c%0d", i), 64'({strobe[2], strobe[0]}), 64'(0));
      if (i == 11) begin
        check("retune ready", 64'(cfg_if.cfg_ready), 64'(1));
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 2'd1;
        cfg_if.cfg_freq  = 12'd500;
        cfg_if.cfg_step  = 8'd1;
      end else if (i == 12) begin
        cfg_if.cfg_valid = 1'b0;
      end
    end
    exp_period[1] = 32'd24;
    check_lanes("retune");
    enable = '0;
    tick();
    tick();

    // Reset during the tenth divide cycle
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'd0;
    cfg_if.cfg_freq  = 12'd500;
    cfg_if.cfg_step  = 8'd1;
    tick();
    cfg_if.cfg_valid = 1'b0;
    check("middiv ready low", 64'(cfg_if.cfg_ready), 64'(0));
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int k = 0; k < int'(CHANNELS); k++) exp_period[k] = 32'd2;
    check("middiv ready in reset", 64'(cfg_if.cfg_ready), 64'(1));
    tick();
    check("middiv ready after release", 64'(cfg_if.cfg_ready), 64'(1));
    for (int i = 0; i < 50; i++) begin
      tick();
      check($sformatf("middiv period0 c%0d", i), 64'(period[0 +: CNT_W]), 64'(2));
      check($sformatf("middiv ready c%0d", i), 64'(cfg_if.cfg_ready), 64'(1));
    end
    check_lanes("middiv");
    check("middiv err", 64'(cfg_if.cfg_err), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_rate_gen.md
# sample_rate_gen

Multi-channel sample-strobe generator for the signal-generator datapath; successor to the single-channel start clock. For each channel it turns a requested output frequency and table step into a period `floor(CLK_HZ*step / (freq*TABLE_LEN))` CLOCK cycles, using one shared sequential divider instead of a combinational divide. Each channel emits a one-cycle `strobe` per period plus a legacy toggling square output. The waveform table readers consume these outputs.

## Interface

- `CLK_HZ`, 100_000_000, system clock frequency in Hz.
- `CHANNELS`, 2, number of independent channels (≥1).
- `FREQ_W`, 12, width of the frequency request in Hz.
- `STEP_W`, 8, width of the table step.
- `TABLE_LEN`, 8192, waveform table length; must be a power of two.
- `CNT_W`, 32, width of the period and counter.
- Derived: `CH_W = max(1, clog2(CHANNELS))`; `DIV_W = clog2(CLK_HZ+1) + STEP_W` (dividend width and divide cycle count).
- `CLOCK` in 1: sole clock; all logic on rising edge.
- `reset` in 1: synchronous, active-low reset.
- `cfg_valid` in 1: configuration request.
- `cfg_ready` out 1: high only when the divider FSM is IDLE.
- `cfg_ch` in CH_W: target channel.
- `cfg_freq` in FREQ_W: requested frequency in Hz.
- `cfg_step` in STEP_W: table step.
- `cfg_err` out 1: one-cycle pulse when a request is rejected.
- `enable` in CHANNELS: per-channel run enable.
- `strobe` out CHANNELS: one-cycle pulse at each period end.
- `square` out CHANNELS: toggles on each strobe.
- `period` out CHANNELS*CNT_W: active period per channel; channel k occupies bits [k*CNT_W +: CNT_W].

## Operation

- **Handshake:** a request is accepted when `cfg_valid && cfg_ready`. Inputs are sampled only in the accept cycle. A `cfg_ch` ≥ CHANNELS, a zero `cfg_freq`, or a zero `cfg_step` is rejected: `cfg_err` pulses in the next cycle, the FSM stays IDLE, and no state changes.
- **FSM states:**
  - IDLE → DIV on a valid accept.
  - DIV runs a restoring divide, one quotient bit per cycle, for DIV_W cycles. Dividend = `CLK_HZ*cfg_step`. Divisor = `cfg_freq << clog2(TABLE_LEN)`. DIV → DONE.
  - DONE lasts one cycle: the clamped quotient is written into the channel's pending register and its pending flag is set. DONE → IDLE.
- **Clamp rules:** a quotient > 2^CNT_W−1 saturates to 2^CNT_W−1. A quotient < 2 is forced to 2.
- **Channel counter:** each channel has a counter `cnt` (CNT_W bits).
  - When `enable[k]` is high, `cnt` increments. When `cnt == period[k]−1`, `strobe[k]` is high that cycle, `square[k]` toggles, and `cnt` wraps to 0.
  - When `enable[k]` is low, `cnt` is held at 0 and `strobe[k]` and `square[k]` are low.
- **Glitch-free update:** a pending period is copied into `period[k]` and its flag cleared at that channel's next wrap, or immediately if the channel is disabled. A second request to the same channel before it is applied overwrites the pending value.
- **Simultaneous events:**
  - A wrap and a DONE write to the same channel in the same cycle: the wrap uses the old period. The new value stays pending until the following wrap.
  - Channels are fully independent.
- **Reset mid-divide:** the divide is abandoned and nothing is written.

## Timing

- **Reset values:** `cfg_ready`=1, `cfg_err`=0, all `strobe`=0, all `square`=0, all counters 0, all pending flags 0, every `period` lane = 2, FSM = IDLE.
- **Configuration latency:** accept at cycle 0, DIV during cycles 1..DIV_W, DONE at DIV_W+1, `cfg_ready` high again at DIV_W+2. With defaults DIV_W=35, so the next accept is possible at cycle 37.
- **First strobe:** with `enable` rising at cycle e, the first strobe occurs at cycle e+period−1. After that, one strobe every `period` cycles.
- **Square output:** `square` frequency = CLOCK/(2*period).
- **Registered outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Structure

- **Package `sample_rate_pkg`:** FSM state enum (IDLE, DIV, DONE), the `clog2` helper, and the DIV_W derivation.
- **Sub-module `seq_divider`:** parametrised restoring unsigned divider with start/done, DIV_W-bit dividend, divisor and quotient. It has no clamping; the clamp lives in the top level.
- **Per-channel logic:** a generate loop containing counter, pending register, pending flag, strobe and square.

## Test plan

- **Reset:** hold `reset`=0 for 3 cycles with random inputs → all outputs at their reset values; `period` lanes = 2.
- **Baseline:** cfg ch0 freq=1000 step=1, then enable[0] → `cfg_ready` low for 36 cycles; period[0]=12; strobe every 12 cycles; `square` period 24 cycles.
- **Range corners:**
  - freq=2828 step=255 → period 1100.
  - freq=1 step=255 → period 3112792.
  - freq=4095 step=1 → period 2, strobe every other cycle.
- **Rejection:** freq=0, step=0, or ch=CHANNELS each → `cfg_err` pulses next cycle, `cfg_ready` stays 1, periods unchanged.
- **Live retune:** ch1 running at period 12; reconfigure to freq=500 step=1 (period 24) → the in-flight 12-cycle period completes; intervals after it are 24; `strobe` and `square` never glitch.
- **Reset mid-divide:** assert `reset` at cycle 10 of DIV → period unchanged, no pending flag set; `cfg_ready` is 1 in the first cycle after reset is released.
